// File: rtl/ceespu_memstage_if.sv
// ceespu_memstage_if -- signal bundle around the Ceespu memory stage.
//
// Groups three links:
//   execute -> memstage : I_valid, I_isLoad, I_isStore, I_selMem, I_selWb,
//                         I_PC, I_aluResult, I_storeData, I_regDst, I_regWe
//                         and O_stall back to execute
//   memstage <-> dmem   : O_dmemReq, O_dmemAddr, O_dmemWe, O_dmemWData,
//                         I_dmemAck, I_dmemRData
//   memstage -> wb      : O_valid, O_selWb, O_selMem, O_PC, O_aluResult,
//                         O_dmemData, O_regDst, O_regWe
//                         (+ O_misaligned when CEESPU_MISALIGN_TRAP_EN is defined)
// Modport slave is taken by the memory stage; master by its environment.
interface ceespu_memstage_if;
    logic        I_valid;
    logic        I_isLoad;
    logic        I_isStore;
    logic [2:0]  I_selMem;
    logic [1:0]  I_selWb;
    logic [13:0] I_PC;
    logic [31:0] I_aluResult;
    logic [31:0] I_storeData;
    logic [4:0]  I_regDst;
    logic        I_regWe;
    logic        O_stall;

    logic        O_dmemReq;
    logic [29:0] O_dmemAddr;
    logic [3:0]  O_dmemWe;
    logic [31:0] O_dmemWData;
    logic        I_dmemAck;
    logic [31:0] I_dmemRData;

    logic        O_valid;
    logic [1:0]  O_selWb;
    logic [2:0]  O_selMem;
    logic [13:0] O_PC;
    logic [31:0] O_aluResult;
    logic [31:0] O_dmemData;
    logic [4:0]  O_regDst;
    logic        O_regWe;
`ifdef CEESPU_MISALIGN_TRAP_EN
    logic        O_misaligned;
`endif

    modport slave (
`ifdef CEESPU_MISALIGN_TRAP_EN
        output O_misaligned,
`endif
        input  I_valid, I_isLoad, I_isStore, I_selMem, I_selWb, I_PC,
               I_aluResult, I_storeData, I_regDst, I_regWe,
               I_dmemAck, I_dmemRData,
        output O_stall, O_dmemReq, O_dmemAddr, O_dmemWe, O_dmemWData,
               O_valid, O_selWb, O_selMem, O_PC, O_aluResult, O_dmemData,
               O_regDst, O_regWe
    );

    modport master (
`ifdef CEESPU_MISALIGN_TRAP_EN
        input  O_misaligned,
`endif
        output I_valid, I_isLoad, I_isStore, I_selMem, I_selWb, I_PC,
               I_aluResult, I_storeData, I_regDst, I_regWe,
               I_dmemAck, I_dmemRData,
        input  O_stall, O_dmemReq, O_dmemAddr, O_dmemWe, O_dmemWData,
               O_valid, O_selWb, O_selMem, O_PC, O_aluResult, O_dmemData,
               O_regDst, O_regWe
    );
endinterface

// File: rtl/ceespu_memstage.sv
// ceespu_memstage -- memory stage of the Ceespu pipeline.
//
// Non-memory instructions retire one cycle after acceptance. Loads and stores
// latch their access, go BUSY and hold a request on the data memory until it
// acknowledges; the instruction then retires with the returned bus word.
// Upstream is stalled for every BUSY cycle.
//
// Ports:
//   I_clk  - clock, rising edge
//   I_rst  - synchronous active-high reset (drops any outstanding request)
//   bus    - ceespu_memstage_if.slave (execute, data memory, writeback links)
//
// Build option: define CEESPU_MISALIGN_TRAP_EN to trap misaligned word/half
// accesses (no request, retire in one cycle with O_regWe=0 and O_misaligned=1).
module ceespu_memstage (
    input  logic             I_clk,
    input  logic             I_rst,
    ceespu_memstage_if.slave bus
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_r;
    state_t      state_s;
    logic        is_mem_s;
    logic        misalign_s;
    logic [3:0]  we_s;
    logic [31:0] wdata_s;

    logic [31:0] addr_r;
    logic [3:0]  we_r;
    logic [31:0] wdata_r;
    logic [1:0]  pend_sel_wb_r;
    logic [2:0]  pend_sel_mem_r;
    logic [13:0] pend_pc_r;
    logic [4:0]  pend_reg_dst_r;
    logic        pend_reg_we_r;

    // Size codes: 0 = word, 1 = half, 2 = byte; anything else acts as word.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            3'd1:    lane_enables = lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    lane_enables = 4'b0001 << lo;
            default: lane_enables = 4'b1111;
        endcase
    endfunction

    // Replicate the stored item across every lane so the enables pick it out.
    function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] d);
        case (size)
            3'd1:    lane_data = {2{d[15:0]}};
            3'd2:    lane_data = {4{d[7:0]}};
            default: lane_data = d;
        endcase
    endfunction

    // A load with the store bit also set behaves as a store.
    assign is_mem_s = bus.I_isLoad | bus.I_isStore;
    assign we_s     = bus.I_isStore ? lane_enables(bus.I_selMem, bus.I_aluResult[1:0]) : 4'b0000;
    assign wdata_s  = lane_data(bus.I_selMem, bus.I_storeData);

`ifdef CEESPU_MISALIGN_TRAP_EN
    assign misalign_s = is_mem_s &&
                        (((bus.I_selMem == 3'd0) && (bus.I_aluResult[1:0] != 2'b00)) ||
                         ((bus.I_selMem == 3'd1) && bus.I_aluResult[0]));
`else
    assign misalign_s = 1'b0;
`endif

    // The bus request mirrors the state flop; address/enables/data are latched.
    assign bus.O_stall     = (state_r == BUSY);
    assign bus.O_dmemReq   = (state_r == BUSY);
    assign bus.O_dmemAddr  = addr_r[31:2];
    assign bus.O_dmemWe    = we_r;
    assign bus.O_dmemWData = wdata_r;

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: only an aligned memory op leaves IDLE; only an ack leaves BUSY.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.I_valid && is_mem_s && !misalign_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.I_dmemAck) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Latch memory accesses, and update the writeback outputs on retirement only.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            addr_r           <= 32'd0;
            we_r             <= 4'd0;
            wdata_r          <= 32'd0;
            pend_sel_wb_r    <= 2'd0;
            pend_sel_mem_r   <= 3'd0;
            pend_pc_r        <= 14'd0;
            pend_reg_dst_r   <= 5'd0;
            pend_reg_we_r    <= 1'b0;
            bus.O_valid      <= 1'b0;
            bus.O_selWb      <= 2'd0;
            bus.O_selMem     <= 3'd0;
            bus.O_PC         <= 14'd0;
            bus.O_aluResult  <= 32'd0;
            bus.O_dmemData   <= 32'd0;
            bus.O_regDst     <= 5'd0;
            bus.O_regWe      <= 1'b0;
`ifdef CEESPU_MISALIGN_TRAP_EN
            bus.O_misaligned <= 1'b0;
`endif
        end else begin
            bus.O_valid      <= 1'b0;
`ifdef CEESPU_MISALIGN_TRAP_EN
            bus.O_misaligned <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (bus.I_valid && (!is_mem_s || misalign_s)) begin
                        // Retire directly: plain ALU op, or a trapped misaligned access.
                        bus.O_valid     <= 1'b1;
                        bus.O_selWb     <= bus.I_selWb;
                        bus.O_selMem    <= bus.I_selMem;
                        bus.O_PC        <= bus.I_PC;
                        bus.O_aluResult <= bus.I_aluResult;
                        bus.O_regDst    <= bus.I_regDst;
                        bus.O_regWe     <= bus.I_regWe & ~misalign_s;
`ifdef CEESPU_MISALIGN_TRAP_EN
                        bus.O_misaligned <= misalign_s;
`endif
                    end else if (bus.I_valid) begin
                        addr_r         <= bus.I_aluResult;
                        we_r           <= we_s;
                        wdata_r        <= wdata_s;
                        pend_sel_wb_r  <= bus.I_selWb;
                        pend_sel_mem_r <= bus.I_selMem;
                        pend_pc_r      <= bus.I_PC;
                        pend_reg_dst_r <= bus.I_regDst;
                        pend_reg_we_r  <= bus.I_regWe;
                    end
                end
                BUSY: begin
                    if (bus.I_dmemAck) begin
                        // Stores capture whatever the bus returns as well.
                        bus.O_valid     <= 1'b1;
                        bus.O_dmemData  <= bus.I_dmemRData;
                        bus.O_selWb     <= pend_sel_wb_r;
                        bus.O_selMem    <= pend_sel_mem_r;
                        bus.O_PC        <= pend_pc_r;
                        bus.O_aluResult <= addr_r;
                        bus.O_regDst    <= pend_reg_dst_r;
                        bus.O_regWe     <= pend_reg_we_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_memstage.sv
module tb_ceespu_memstage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ceespu_memstage_if bus_if();
    ceespu_memstage dut (.I_clk(clk), .I_rst(rst), .bus(bus_if));

    typedef struct {
        logic        is_load;
        logic        is_store;
        logic [2:0]  sel_mem;
        logic [1:0]  sel_wb;
        logic [13:0] pc;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  reg_dst;
        logic        reg_we;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata;
        logic [29:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [1:0]  sel_wb;
        logic [2:0]  sel_mem;
        logic [13:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  reg_dst;
        logic        reg_we;
        logic        mis;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t got_e;
    vec_t tbl[11];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every retirement is popped and compared here.
    always @(negedge clk) begin
        if (bus_if.O_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_retire", {31'd0, bus_if.O_valid}, 32'd0);
            end else begin
                got_e = sb_q.pop_front();
                check("latency", cyc - got_e.issue, got_e.lat);
                check("o_selwb", {30'd0, bus_if.O_selWb}, {30'd0, got_e.sel_wb});
                check("o_selmem", {29'd0, bus_if.O_selMem}, {29'd0, got_e.sel_mem});
                check("o_pc", {18'd0, bus_if.O_PC}, {18'd0, got_e.pc});
                check("o_aluresult", bus_if.O_aluResult, got_e.alu);
                check("o_regdst", {27'd0, bus_if.O_regDst}, {27'd0, got_e.reg_dst});
                check("o_regwe", {31'd0, bus_if.O_regWe}, {31'd0, got_e.reg_we});
                if (got_e.chk_data) check("o_dmemdata", bus_if.O_dmemData, got_e.data);
`ifdef CEESPU_MISALIGN_TRAP_EN
                check("o_misaligned", {31'd0, bus_if.O_misaligned}, {31'd0, got_e.mis});
`endif
            end
        end
    end

    task automatic drive_idle();
        bus_if.I_valid     = 1'b0;
        bus_if.I_isLoad    = 1'b0;
        bus_if.I_isStore   = 1'b0;
        bus_if.I_selMem    = 3'd0;
        bus_if.I_selWb     = 2'd0;
        bus_if.I_PC        = 14'd0;
        bus_if.I_aluResult = 32'd0;
        bus_if.I_storeData = 32'd0;
        bus_if.I_regDst    = 5'd0;
        bus_if.I_regWe     = 1'b0;
        bus_if.I_dmemAck   = 1'b0;
        bus_if.I_dmemRData = 32'd0;
    endtask

    task automatic drive_op(input vec_t v);
        bus_if.I_valid     = 1'b1;
        bus_if.I_isLoad    = v.is_load;
        bus_if.I_isStore   = v.is_store;
        bus_if.I_selMem    = v.sel_mem;
        bus_if.I_selWb     = v.sel_wb;
        bus_if.I_PC        = v.pc;
        bus_if.I_aluResult = v.alu;
        bus_if.I_storeData = v.sdata;
        bus_if.I_regDst    = v.reg_dst;
        bus_if.I_regWe     = v.reg_we;
    endtask

    task automatic push_exp(input vec_t v, input int lat, input logic mis);
        exp_t e;
        e.sel_wb   = v.sel_wb;
        e.sel_mem  = v.sel_mem;
        e.pc       = v.pc;
        e.alu      = v.alu;
        e.data     = v.rdata;
        e.chk_data = (lat > 1);
        e.reg_dst  = v.reg_dst;
        e.reg_we   = mis ? 1'b0 : v.reg_we;
        e.mis      = mis;
        e.issue    = cyc;
        e.lat      = lat;
        sb_q.push_back(e);
    endtask

    // One instruction end to end, with junk on the execute inputs while busy.
    task automatic apply_op(input vec_t v);
        logic mem;
        mem = v.is_load | v.is_store;
        @(negedge clk);
        drive_op(v);
        push_exp(v, mem ? v.waits + 2 : 1, 1'b0);
        @(negedge clk);
        if (!mem) begin
            drive_idle();
            check("stall_nonmem", {31'd0, bus_if.O_stall}, 32'd0);
            check("req_nonmem", {31'd0, bus_if.O_dmemReq}, 32'd0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                bus_if.I_valid     = 1'b1;
                bus_if.I_isLoad    = 1'b0;
                bus_if.I_isStore   = 1'b1;
                bus_if.I_aluResult = $urandom;
                bus_if.I_storeData = $urandom;
                bus_if.I_PC        = 14'($urandom);
                check("stall_busy", {31'd0, bus_if.O_stall}, 32'd1);
                check("req_busy", {31'd0, bus_if.O_dmemReq}, 32'd1);
                check("dmem_addr", {2'd0, bus_if.O_dmemAddr}, {2'd0, v.exp_addr});
                check("dmem_we", {28'd0, bus_if.O_dmemWe}, {28'd0, v.exp_we});
                if (v.is_store) check("dmem_wdata", bus_if.O_dmemWData, v.exp_wdata);
                if (w == v.waits) begin
                    bus_if.I_dmemAck   = 1'b1;
                    bus_if.I_dmemRData = v.rdata;
                end
                @(negedge clk);
            end
            drive_idle();
            check("stall_after", {31'd0, bus_if.O_stall}, 32'd0);
            check("req_after", {31'd0, bus_if.O_dmemReq}, 32'd0);
        end
        @(negedge clk);
        check("valid_pulse", {31'd0, bus_if.O_valid}, 32'd0);
    endtask

    initial begin
        vec_t v;
        //           ld    st    sel   wb    pc        alu           sdata         dst   we    w  rdata         we       wdata         addr
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 2'd2, 14'h0011, 32'h12345678, 32'h00000000, 5'd3, 1'b1, 0, 32'h00000000, 4'b0000, 32'h00000000, 30'h0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 2'd1, 14'h0012, 32'h00000100, 32'h55555555, 5'd4, 1'b1, 3, 32'hDEADBEEF, 4'b0000, 32'h00000000, 30'h40};
        tbl[2]  = '{1'b0, 1'b1, 3'd2, 2'd0, 14'h0013, 32'h00000203, 32'h000000A5, 5'd0, 1'b0, 0, 32'h13572468, 4'b1000, 32'hA5A5A5A5, 30'h80};
        tbl[3]  = '{1'b0, 1'b1, 3'd1, 2'd0, 14'h0014, 32'h00000202, 32'h0000BEEF, 5'd0, 1'b0, 1, 32'h2468ACE0, 4'b1100, 32'hBEEFBEEF, 30'h80};
        tbl[4]  = '{1'b0, 1'b1, 3'd1, 2'd0, 14'h0015, 32'h00000200, 32'hFFFF5678, 5'd0, 1'b0, 0, 32'h11110000, 4'b0011, 32'h56785678, 30'h80};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 2'd0, 14'h0016, 32'h00000300, 32'hCAFEF00D, 5'd0, 1'b0, 2, 32'h00002222, 4'b1111, 32'hCAFEF00D, 30'hC0};
        tbl[6]  = '{1'b0, 1'b1, 3'd2, 2'd0, 14'h0017, 32'h00000401, 32'h11223344, 5'd0, 1'b0, 0, 32'h33330000, 4'b0010, 32'h44444444, 30'h100};
        tbl[7]  = '{1'b1, 1'b1, 3'd0, 2'd1, 14'h0018, 32'h00000500, 32'h0BADF00D, 5'd9, 1'b1, 0, 32'h77777777, 4'b1111, 32'h0BADF00D, 30'h140};
        tbl[8]  = '{1'b1, 1'b0, 3'd2, 2'd1, 14'h0019, 32'h00000013, 32'h99999999, 5'd7, 1'b1, 2, 32'h01020304, 4'b0000, 32'h00000000, 30'h4};
        tbl[9]  = '{1'b0, 1'b0, 3'd5, 2'd3, 14'h3FFF, 32'hFFFFFFFF, 32'h00000000, 5'd31, 1'b0, 0, 32'h00000000, 4'b0000, 32'h00000000, 30'h0};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 2'd0, 14'h001A, 32'h00000200, 32'h000000C3, 5'd0, 1'b0, 0, 32'h0000C3C3, 4'b0001, 32'hC3C3C3C3, 30'h80};

        // Reset state.
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, bus_if.O_valid}, 32'd0);
        check("rst_stall", {31'd0, bus_if.O_stall}, 32'd0);
        check("rst_req", {31'd0, bus_if.O_dmemReq}, 32'd0);
        check("rst_addr", {2'd0, bus_if.O_dmemAddr}, 32'd0);
        check("rst_we", {28'd0, bus_if.O_dmemWe}, 32'd0);
        check("rst_alu", bus_if.O_aluResult, 32'd0);
        check("rst_data", bus_if.O_dmemData, 32'd0);
        check("rst_regwe", {31'd0, bus_if.O_regWe}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) apply_op(tbl[i]);

        // Ack while idle: no retirement, no request.
        @(negedge clk);
        bus_if.I_dmemAck   = 1'b1;
        bus_if.I_dmemRData = 32'hBAD0BAD0;
        @(negedge clk);
        bus_if.I_dmemAck = 1'b0;
        check("idle_ack_valid", {31'd0, bus_if.O_valid}, 32'd0);
        check("idle_ack_req", {31'd0, bus_if.O_dmemReq}, 32'd0);
        check("idle_ack_data", bus_if.O_dmemData, 32'h0000C3C3);

        // Back-to-back non-memory ops retire on consecutive cycles.
        @(negedge clk);
        drive_op(tbl[0]);
        push_exp(tbl[0], 1, 1'b0);
        @(negedge clk);
        drive_op(tbl[9]);
        push_exp(tbl[9], 1, 1'b0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("b2b_done", {31'd0, bus_if.O_valid}, 32'd0);

        // Reset during BUSY, then a late ack.
        v = tbl[1];
        v.alu = 32'h00000800;
        @(negedge clk);
        drive_op(v);
        @(negedge clk);
        drive_idle();
        check("rstbusy_req_before", {31'd0, bus_if.O_dmemReq}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.I_dmemAck   = 1'b1;
        bus_if.I_dmemRData = 32'hFEEDFACE;
        check("rstbusy_req", {31'd0, bus_if.O_dmemReq}, 32'd0);
        check("rstbusy_stall", {31'd0, bus_if.O_stall}, 32'd0);
        check("rstbusy_alu", bus_if.O_aluResult, 32'd0);
        @(negedge clk);
        bus_if.I_dmemAck = 1'b0;
        check("rstbusy_valid", {31'd0, bus_if.O_valid}, 32'd0);
        check("rstbusy_req_late", {31'd0, bus_if.O_dmemReq}, 32'd0);
        apply_op(tbl[2]);

        // Misaligned word load at 0x102.
        v = tbl[1];
        v.alu = 32'h00000102;
        v.exp_addr = 30'h40;
`ifdef CEESPU_MISALIGN_TRAP_EN
        @(negedge clk);
        drive_op(v);
        push_exp(v, 1, 1'b1);
        @(negedge clk);
        drive_idle();
        check("mis_req", {31'd0, bus_if.O_dmemReq}, 32'd0);
        check("mis_stall", {31'd0, bus_if.O_stall}, 32'd0);
        @(negedge clk);
        check("mis_req_after", {31'd0, bus_if.O_dmemReq}, 32'd0);
`else
        v.waits = 0;
        apply_op(v);
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
